// File: rtl/pll_dyn_cfg_ctrl_pkg.sv
// Shared types for the rPLL dynamic-configuration sequencer: code layout and FSM states.
package pll_dyn_cfg_ctrl_pkg;

    localparam int unsigned CODE_W  = 26;
    localparam int unsigned DIV_W   = 6;
    localparam int unsigned PH_W    = 4;
    localparam int unsigned RETRY_W = 2;

    // Field order matches the packed request word {ids, fbds, ods, psda, duty}.
    typedef struct packed {
        logic [DIV_W-1:0] ids;
        logic [DIV_W-1:0] fbds;
        logic [DIV_W-1:0] ods;
        logic [PH_W-1:0]  psda;
        logic [PH_W-1:0]  duty;
    } pll_code_t;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STAB  = 3'd2,
        ST_RUN   = 3'd3,
        ST_RETRY = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

endpackage

// File: rtl/pll_dyn_cfg_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module pll_dyn_cfg_ctrl_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Sequences rPLL divider/phase code changes: reset hold, lock wait with timeout,
// stability qualification, lock-loss monitoring and bounded automatic relock.
module pll_dyn_cfg_ctrl
    import pll_dyn_cfg_ctrl_pkg::*;
#(
    parameter int unsigned       RST_CYC    = 16,
    parameter int unsigned       LOCK_TMO   = 4800,
    parameter int unsigned       STABLE_CYC = 240,
    parameter int unsigned       MAX_RETRY  = 3,
    parameter logic [CODE_W-1:0] INIT_CODE  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [CODE_W-1:0]  cfg_code,
    output logic               cfg_ready,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               pll_reset_p,
    output logic [DIV_W-1:0]   pll_idsel,
    output logic [DIV_W-1:0]   pll_fbdsel,
    output logic [DIV_W-1:0]   pll_odsel,
    output logic [PH_W-1:0]    pll_psda,
    output logic [PH_W-1:0]    pll_dutyda,
    output logic               clk_ok,
    output logic               busy,
    output logic               err,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned CNT_W  = $clog2(LOCK_TMO + 1);
    localparam int unsigned STAB_W = $clog2(STABLE_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    pll_code_t          code_q, code_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               err_q, err_d;
    logic               pll_reset_q, pll_reset_d;
    logic               clk_ok_q, clk_ok_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               busy_q, busy_d;
    logic               lk;
    logic               accept_c;

    pll_dyn_cfg_ctrl_sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_lock),
        .dout  (lk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            stab_q      <= '0;
            code_q      <= pll_code_t'(INIT_CODE);
            retry_q     <= '0;
            err_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            code_q      <= code_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            pll_reset_q <= pll_reset_d;
            clk_ok_q    <= clk_ok_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stab_d   = stab_q;
        code_d   = code_q;
        retry_d  = retry_q;
        err_d    = err_q;
        accept_c = cfg_valid && cfg_ready_q;

        unique case (state_q)
            // First HOLD cycle lets new codes settle before RESET rises.
            ST_HOLD: begin
                if (cnt_q == CNT_W'(RST_CYC)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (lk) begin
                    state_d = ST_STAB;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_q == CNT_W'(LOCK_TMO - 1)) begin
                    state_d = ST_RETRY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // cnt_q bounds total STAB time; stab_q counts the current lock run.
            ST_STAB: begin
                if (lk && (stab_q == STAB_W'(STABLE_CYC - 1))) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(LOCK_TMO - 1)) begin
                    state_d = ST_RETRY;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    stab_d = lk ? stab_q + STAB_W'(1) : '0;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    retry_d = retry_q + RETRY_W'(1);
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase

        // A request beats a simultaneous lock loss and does not count as a retry.
        if (accept_c) begin
            state_d = ST_HOLD;
            code_d  = pll_code_t'(cfg_code);
            retry_d = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            stab_d  = '0;
        end

        pll_reset_d = ((state_q == ST_HOLD) && (cnt_q != CNT_W'(RST_CYC))) || (state_q == ST_FAIL);
        clk_ok_d    = (state_d == ST_RUN);
        cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
        busy_d      = !cfg_ready_d;
    end

    assign cfg_ready   = cfg_ready_q;
    assign pll_reset   = pll_reset_q;
    assign pll_reset_p = pll_reset_q;
    assign pll_idsel   = code_q.ids;
    assign pll_fbdsel  = code_q.fbds;
    assign pll_odsel   = code_q.ods;
    assign pll_psda    = code_q.psda;
    assign pll_dutyda  = code_q.duty;
    assign clk_ok      = clk_ok_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign retry_cnt   = retry_q;

endmodule
